// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32-entry general register file combined with a one-bit-per-register
//   issue scoreboard. It sits between the ID stage and the WB stage.
//   ID reads operands, is told when to stall, and issues writers.
//   WB writes results back and retires the matching pending bit.
//   A same-cycle write-back is bypassed to the ID read ports and also
//   clears the hazard that it resolves.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset (clears registers and scoreboard)
//   id_valid   ID holds a valid instruction
//   id_writes  ID instruction writes a destination register
//   id_dst     ID destination register number
//   rs_addr    ID source register A
//   rt_addr    ID source register B
//   rs_data    read data A (bypassed, zero latency)
//   rt_data    read data B (bypassed, zero latency)
//   stall      ID must hold; nothing issues this cycle
//   wb_valid   WB write-back valid
//   wb_dst     WB destination register number
//   wb_data    WB write data
//   pending    scoreboard; bit n set = a write to register n is outstanding
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic              id_writes,
  input  logic [4:0]        id_dst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [4:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic [31:0]       pending
);

  logic [DATA_W-1:0] regsQ [32];
  logic [31:0]       pendingQ;
  logic [31:0]       pendingD;
  logic [31:0]       wbOh;
  logic [31:0]       issOh;
  logic [31:0]       busy;
  logic              issue;

  // Decode WB and ID register numbers into one-hot vectors. A register that is
  // being written back this cycle is not busy, because the bypass already
  // delivers its value. The WAW term on id_dst stops a second writer from
  // issuing while a first write is still outstanding.
  always_comb begin
    wbOh = wb_valid ? (32'd1 << wb_dst) : 32'd0;
    if (ZERO_REG) wbOh[0] = 1'b0;

    busy    = pendingQ & ~wbOh;
    busy[0] = 1'b0;

    stall = id_valid & (busy[rs_addr] | busy[rt_addr] | (id_writes & busy[id_dst]));
    issue = id_valid & id_writes & ~stall & (id_dst != 5'd0);

    issOh = issue ? (32'd1 << id_dst) : 32'd0;
    if (ZERO_REG) issOh[0] = 1'b0;

    // The clear is applied before the set, so a same-cycle reissue keeps the bit set.
    pendingD = (pendingQ & ~wbOh) | issOh;
  end

  // Read ports. A matching write-back in this cycle takes priority over the
  // stored value, and register 0 always reads as zero.
  always_comb begin
    rs_data = regsQ[rs_addr];
    if (wb_valid && (wb_dst == rs_addr)) rs_data = wb_data;
    if (ZERO_REG && (rs_addr == 5'd0)) rs_data = '0;

    rt_data = regsQ[rt_addr];
    if (wb_valid && (wb_dst == rt_addr)) rt_data = wb_data;
    if (ZERO_REG && (rt_addr == 5'd0)) rt_data = '0;
  end

  // Register and scoreboard state. Reset takes priority over a same-cycle
  // issue or write-back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pendingQ <= '0;
      for (int i = 0; i < 32; i++) regsQ[i] <= '0;
    end else begin
      pendingQ <= pendingD;
      for (int i = 0; i < 32; i++) begin
        if (wbOh[i]) regsQ[i] <= wb_data;
      end
    end
  end

  assign pending = pendingQ;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard. A behavioural model built
//   from arrays holds the register values and the outstanding-write flags.
//   Each scenario task drives the inputs and compares the DUT outputs with
//   the model before every rising edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic        id_writes;
  logic [4:0]  id_dst;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  logic [31:0] mReg [32];
  logic [31:0] mPend;

  regfile_scoreboard #(.DATA_W(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_writes(id_writes), .id_dst(id_dst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Model: a register n is busy while its write is outstanding. A write-back
  // to n in the same cycle resolves the hazard. Register 0 is never busy.
  function automatic logic mBusy(input logic [4:0] n);
    return (n != 5'd0) && mPend[n] && !(wb_valid && (wb_dst == n));
  endfunction

  function automatic logic mStall();
    return id_valid && (mBusy(rs_addr) || mBusy(rt_addr) || (id_writes && mBusy(id_dst)));
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_valid && (wb_dst == a)) return wb_data;
    return mReg[a];
  endfunction

  task automatic idle();
    resetn = 1'b1; id_valid = 1'b0; id_writes = 1'b0; id_dst = '0;
    rs_addr = '0; rt_addr = '0; wb_valid = 1'b0; wb_dst = '0; wb_data = '0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic iss;
    logic [4:0] idD, wbD;
    logic wbV, rst;
    logic [31:0] wbX;
    iss = id_valid && id_writes && !mStall() && (id_dst != 5'd0);
    idD = id_dst; wbD = wb_dst; wbV = wb_valid; wbX = wb_data; rst = !resetn;
    @(posedge clk);
    if (rst) begin
      mPend = '0;
      for (int i = 0; i < 32; i++) mReg[i] = '0;
    end else begin
      if (wbV && (wbD != 5'd0)) begin
        mReg[wbD] = wbX;
        mPend[wbD] = 1'b0;
      end
      if (iss) mPend[idD] = 1'b1;
    end
    #1;
  endtask

  task automatic doReset();
    idle();
    resetn = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0; wb_valid = 1'b1; wb_dst = 5'd5; wb_data = $urandom;
    tick(); tick();
    idle();
    rs_addr = 5'd5; rt_addr = 5'd5; id_valid = 1'b1;
    #1;
    checks++; if (pending !== 32'd0) begin errors++; $display("[TB] FAIL reset_pending got %h expected %h", pending, 32'd0); end
    checks++; if (rs_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rs got %h expected %h", rs_data, 32'd0); end
    checks++; if (rt_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rt got %h expected %h", rt_data, 32'd0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_issue_wb();
    doReset();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd8;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL iss_stall got %b expected 0", stall); end
    tick();
    idle();
    id_valid = 1'b1; rs_addr = 5'd8;
    #1;
    checks++; if (pending !== 32'h0000_0100) begin errors++; $display("[TB] FAIL iss_pending got %h expected %h", pending, 32'h100); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall got %b expected 1", stall); end
    tick();
    wb_valid = 1'b1; wb_dst = 5'd8; wb_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL bypass_stall got %b expected 0", stall); end
    checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bypass_rs got %h expected %h", rs_data, 32'hDEADBEEF); end
    tick();
    idle();
    rt_addr = 5'd8;
    #1;
    checks++; if (pending !== 32'd0) begin errors++; $display("[TB] FAIL wb_pending got %h expected %h", pending, 32'd0); end
    checks++; if (rt_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wb_rt got %h expected %h", rt_data, 32'hDEADBEEF); end
    idle();
  endtask

  task automatic test_reg0();
    doReset();
    wb_valid = 1'b1; wb_dst = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (rs_data !== 32'd0) begin errors++; $display("[TB] FAIL r0_bypass got %h expected %h", rs_data, 32'd0); end
    tick();
    idle();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd0;
    #1;
    checks++; if (rt_data !== 32'd0) begin errors++; $display("[TB] FAIL r0_read got %h expected %h", rt_data, 32'd0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL r0_stall got %b expected 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (pending !== 32'd0) begin errors++; $display("[TB] FAIL r0_pending got %h expected %h", pending, 32'd0); end
  endtask

  task automatic test_same_cycle();
    doReset();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd3;
    tick();
    idle();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd3;
    wb_valid = 1'b1; wb_dst = 5'd3; wb_data = 32'h1234_5678;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL same_stall got %b expected 0", stall); end
    tick();
    idle();
    rs_addr = 5'd3;
    #1;
    checks++; if (pending !== 32'h0000_0008) begin errors++; $display("[TB] FAIL same_pending got %h expected %h", pending, 32'h8); end
    checks++; if (rs_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL same_data got %h expected %h", rs_data, 32'h12345678); end
  endtask

  task automatic test_waw();
    doReset();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd12;
    tick();
    idle();
    id_valid = 1'b1; id_writes = 1'b1; id_dst = 5'd12; rs_addr = 5'd1; rt_addr = 5'd2;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL waw_stall got %b expected 1", stall); end
    tick();
    #1;
    checks++; if (pending !== 32'h0000_1000) begin errors++; $display("[TB] FAIL waw_pending got %h expected %h", pending, 32'h1000); end
    id_writes = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL waw_nowrite_stall got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_decoder_sweep();
    logic [31:0] val;
    doReset();
    for (int n = 1; n < 32; n++) begin
      val = n * 32'h0101_0101;
      idle();
      id_valid = 1'b1; id_writes = 1'b1; id_dst = n[4:0];
      tick();
      idle();
      #1;
      checks++; if (pending !== (32'd1 << n)) begin errors++; $display("[TB] FAIL sweep_pending_%0d got %h expected %h", n, pending, 32'd1 << n); end
      wb_valid = 1'b1; wb_dst = n[4:0]; wb_data = val;
      tick();
      idle();
      rs_addr = n[4:0];
      #1;
      checks++; if (rs_data !== val) begin errors++; $display("[TB] FAIL sweep_data_%0d got %h expected %h", n, rs_data, val); end
      checks++; if (pending !== 32'd0) begin errors++; $display("[TB] FAIL sweep_clear_%0d got %h expected %h", n, pending, 32'd0); end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] eRs, eRt;
    logic eSt;
    doReset();
    for (int c = 0; c < 400; c++) begin
      resetn    = ($urandom_range(0, 99) != 0);
      id_valid  = $urandom_range(0, 3) != 0;
      id_writes = $urandom_range(0, 1);
      id_dst    = $urandom_range(0, 31);
      rs_addr   = $urandom_range(0, 31);
      rt_addr   = $urandom_range(0, 31);
      wb_valid  = $urandom_range(0, 1);
      wb_dst    = (mPend != 0 && $urandom_range(0, 1)) ? 5'($clog2(mPend & -mPend)) : 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      #1;
      eSt = mStall(); eRs = mRead(rs_addr); eRt = mRead(rt_addr);
      checks++; if (pending !== mPend) begin errors++; $display("[TB] FAIL rnd_pending cyc %0d got %h expected %h", c, pending, mPend); end
      checks++; if (stall !== eSt) begin errors++; $display("[TB] FAIL rnd_stall cyc %0d got %b expected %b", c, stall, eSt); end
      checks++; if (rs_data !== eRs) begin errors++; $display("[TB] FAIL rnd_rs cyc %0d got %h expected %h", c, rs_data, eRs); end
      checks++; if (rt_data !== eRt) begin errors++; $display("[TB] FAIL rnd_rt cyc %0d got %h expected %h", c, rt_data, eRt); end
      tick();
    end
    idle();
  endtask

  initial begin
    mPend = '0;
    for (int i = 0; i < 32; i++) mReg[i] = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_issue_wb();
    test_reg0();
    test_same_cycle();
    test_waw();
    test_decoder_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
